// File: rtl/xdata_pkg.sv
// Shared definitions for the xdata RAM arbiter: owner encoding, default widths
// and the peripheral addresses that live in the xdata window.
package xdata_pkg;

  localparam int unsigned XD_ADDR_W    = 9;
  localparam int unsigned XD_DATA_W    = 8;
  localparam int unsigned XD_BURST_MAX = 4;
  localparam int unsigned XD_CNT_W     = 4;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  // Low bits of the 16'h0200/16'h0201 peripheral window
  localparam logic [XD_ADDR_W-1:0] UART_STAT = XD_ADDR_W'(16'h0200);
  localparam logic [XD_ADDR_W-1:0] UART_DATA = XD_ADDR_W'(16'h0201);

  function automatic owner_e own_of(input logic sel);
    return sel ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/xdata_rr_pick.sv
// Combinational winner selection: lock owner first, then lone requester,
// then round-robin priority when both request.
module xdata_rr_pick
  import xdata_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_owner,
  input  logic       i_prio,
  output logic [1:0] o_gnt_c
);

  always_comb begin
    o_gnt_c = 2'b00;
    if (i_owner == OWN0 && i_req[0]) begin
      o_gnt_c = 2'b01;
    end else if (i_owner == OWN1 && i_req[1]) begin
      o_gnt_c = 2'b10;
    end else begin
      case (i_req)
        2'b01:   o_gnt_c = 2'b01;
        2'b10:   o_gnt_c = 2'b10;
        2'b11:   o_gnt_c = i_prio ? 2'b10 : 2'b01;
        default: o_gnt_c = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/xdata_mem_arb.sv
// Two-requester round-robin arbiter for the single-port xdata RAM, with
// bounded burst locking and one-cycle read-data return to the winner.
module xdata_mem_arb
  import xdata_pkg::*;
#(
  parameter int unsigned ADDR_W    = XD_ADDR_W,
  parameter int unsigned DATA_W    = XD_DATA_W,
  parameter int unsigned BURST_MAX = XD_BURST_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_wr0,
  input  logic              i_lock0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_data0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_wr1,
  input  logic              i_lock1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_any;
  logic                w_sel;
  logic                w_wr_sel;
  logic                w_lock_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [XD_CNT_W-1:0] w_cnt_inc;
  logic [XD_CNT_W-1:0] w_cnt_nxt;
  owner_e              w_owner_nxt;
  logic                w_prio_nxt;

  owner_e              r_owner;
  logic [XD_CNT_W-1:0] r_cnt;
  logic                r_prio;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [1:0]          r_rvalid;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  // Reset masks requests so no grant or write strobe escapes during reset
  assign w_req = {i_req1, i_req0} & {2{~i_rst}};

  xdata_rr_pick u_pick (
    .i_req   (w_req),
    .i_owner (r_owner),
    .i_prio  (r_prio),
    .o_gnt_c (w_gnt)
  );

  assign w_any      = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_wr_sel   = w_sel ? i_wr1   : i_wr0;
  assign w_lock_sel = w_sel ? i_lock1 : i_lock0;
  assign w_addr_sel = w_sel ? i_addr1 : i_addr0;
  assign w_cnt_inc  = r_cnt + XD_CNT_W'(1);

  assign o_gnt0     = w_gnt[0];
  assign o_gnt1     = w_gnt[1];
  assign o_mem_wr   = w_any & w_wr_sel;
  assign o_mem_addr = w_any ? w_addr_sel : r_last_addr;
  assign o_mem_data = w_sel ? i_data1 : i_data0;

  // Read data is forwarded in the completion cycle and held afterwards
  assign o_rvalid0 = r_rvalid[0] & ~i_rst;
  assign o_rvalid1 = r_rvalid[1] & ~i_rst;
  assign o_rdata0  = o_rvalid0 ? i_mem_data : r_rdata0;
  assign o_rdata1  = o_rvalid1 ? i_mem_data : r_rdata1;

  // Owner/burst/priority next state; any cycle without a grant drops the lock
  always_comb begin
    w_owner_nxt = NONE;
    w_cnt_nxt   = '0;
    w_prio_nxt  = r_prio;
    if (w_any) begin
      if (w_lock_sel && (w_cnt_inc < XD_CNT_W'(BURST_MAX))) begin
        w_owner_nxt = own_of(w_sel);
        w_cnt_nxt   = w_cnt_inc;
      end else begin
        w_prio_nxt  = ~w_sel;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= NONE;
      r_cnt   <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_addr <= '0;
      r_rvalid    <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      if (w_any) r_last_addr <= w_addr_sel;
      r_rvalid <= w_gnt & ~{i_wr1, i_wr0};
      if (r_rvalid[0]) r_rdata0 <= i_mem_data;
      if (r_rvalid[1]) r_rdata1 <= i_mem_data;
    end
  end

endmodule
